// File: rtl/ysyx_24080006_hpm_counter_bank.sv
// Bank of event-selectable hardware performance counters with sticky overflow
// flags and an atomic snapshot copy for coherent multi-word CSR reads.
module ysyx_24080006_hpm_counter_bank #(
  parameter int NUM_CNT    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16,
  parameter int SEL_W      = $clog2(NUM_EVENTS),
  parameter int IDX_W      = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic                  cfg_inhibit,
  input  logic                  cnt_we_lo,
  input  logic                  cnt_we_hi,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [31:0]           wdata,
  input  logic                  snap_req,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic                  rd_snap,
  output logic [31:0]           rdata_lo,
  output logic [31:0]           rdata_hi,
  output logic [NUM_CNT-1:0]    ovf_flags,
  output logic                  ovf_irq
);

  localparam int HI_W     = CNT_WIDTH - 32;
  localparam int EV_PAD_W = 1 << SEL_W;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  cnt_t                cnt_q    [NUM_CNT];
  cnt_t                shadow_q [NUM_CNT];
  cnt_t                cnt_d    [NUM_CNT];
  logic [SEL_W-1:0]    sel_q    [NUM_CNT];
  logic [NUM_CNT-1:0]  inhibit_q;
  logic [NUM_CNT-1:0]  wr_hit;
  logic [NUM_CNT-1:0]  wrap;
  logic [EV_PAD_W-1:0] ev_pad;
  cnt_t                rd_val;

  // Selects at or beyond NUM_EVENTS land on the zero padding and never count.
  assign ev_pad = EV_PAD_W'(event_i);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i]  = cnt_q[i];
      wrap[i]   = 1'b0;
      wr_hit[i] = (wr_idx == IDX_W'(i)) && (cnt_we_hi || cnt_we_lo);
      if ((wr_idx == IDX_W'(i)) && cnt_we_hi) begin
        cnt_d[i][CNT_WIDTH-1:32] = wdata[HI_W-1:0];
      end else if ((wr_idx == IDX_W'(i)) && cnt_we_lo) begin
        cnt_d[i][31:0] = wdata;
      end else if (!inhibit_q[i] && ev_pad[sel_q[i]]) begin
        cnt_d[i] = cnt_q[i] + cnt_t'(1);
        wrap[i]  = &cnt_q[i];
      end
    end
  end

  // NOTE: counter and shadow arrays are cleared element by element because software
  // relies on them reading zero after reset; they are not left as unreset storage.
  // NOTE: state uses <= so every register samples pre-edge values; this is what lets
  // the shadow capture the pre-increment count and config changes apply a cycle late.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
        sel_q[i]    <= '0;
      end
      inhibit_q <= '0;
      ovf_flags <= '0;
      ovf_irq   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_req) begin
          shadow_q[i] <= cnt_q[i];
        end
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          sel_q[i]     <= cfg_sel;
          inhibit_q[i] <= cfg_inhibit;
        end
      end
      // A write blocks the increment, so clear and set never collide on one counter.
      ovf_flags <= (ovf_flags & ~wr_hit) | wrap;
      ovf_irq   <= |wrap;
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_val = rd_snap ? shadow_q[i] : cnt_q[i];
      end
    end
  end

  assign rdata_lo = rd_val[31:0];
  assign rdata_hi = 32'(rd_val[CNT_WIDTH-1:32]);

endmodule

// File: doc/ysyx_24080006_hpm_counter_bank.md
Name: ysyx_24080006_hpm_counter_bank

Overview:
Parametrised bank of NUM_CNT hardware performance counters, each CNT_WIDTH wide and split into 32-bit lo/hi halves for CSR access. Each counter has its own event select, inhibit bit and sticky overflow flag. A snapshot mechanism freezes all counters atomically so software can read coherent multi-word values. The bank sits beside the CSR unit and generalises the fixed single 64-bit cycle/instret counter.

Parameters:
NUM_CNT, 4, number of counters (1..32)
CNT_WIDTH, 64, counter width in bits (33..64); hi half is CNT_WIDTH-32 bits, zero-extended on read
NUM_EVENTS, 16, width of the event input vector (2..64)
SEL_W, $clog2(NUM_EVENTS), event-select field width (derived)
IDX_W, $clog2(NUM_CNT) (min 1), counter index width (derived)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
event_i  in  NUM_EVENTS  per-cycle event strobes, one bit per event
cfg_we  in  1  write event select and inhibit for counter cfg_idx
cfg_idx  in  IDX_W  counter targeted by the config write
cfg_sel  in  SEL_W  event index for the counter
cfg_inhibit  in  1  1 = counter frozen
cnt_we_lo  in  1  write lo half of counter wr_idx
cnt_we_hi  in  1  write hi half of counter wr_idx
wr_idx  in  IDX_W  counter targeted by the data write
wdata  in  32  write data
snap_req  in  1  copy all live counters to shadow registers
rd_idx  in  IDX_W  counter to read
rd_snap  in  1  0 = read live value, 1 = read shadow value
rdata_lo  out  32  lo half of selected value
rdata_hi  out  32  hi half, zero-extended
ovf_flags  out  NUM_CNT  sticky per-counter overflow flags
ovf_irq  out  1  one-cycle pulse on any overflow

Behaviour:
- Reset (async assert, sync release): all counters, shadows, sel, inhibit and ovf_flags = 0; ovf_irq = 0. rdata reads 0. Reset mid-count clears immediately, without waiting for a clock edge.
- Increment condition for counter i: !inhibit[i] && event_i[sel[i]]. If sel[i] >= NUM_EVENTS, the counter never counts.
- Per-counter priority each cycle: cnt_we_hi > cnt_we_lo > increment > hold.
  - Write hi: hi <= wdata[CNT_WIDTH-33:0]; lo unchanged; no increment that cycle.
  - Write lo: lo <= wdata; hi unchanged; no increment.
  - cnt_we_hi and cnt_we_lo together: only hi is written.
  - Writes apply only to counter wr_idx; all other counters increment normally in the same cycle.
- Any data write to counter i also clears ovf_flags[i] on the same edge.
- Increment is a full CNT_WIDTH-bit add with carry from lo into hi.
- Wrap: all-ones + 1 -> 0. On that edge ovf_flags[i] <= 1 (sticky). ovf_irq = 1 in the following cycle only; it is a registered OR of all wraps in the prior cycle. Wrap and a data write to the same counter cannot coincide, because the write blocks the increment.
- cfg_we: sel/inhibit take effect from the next cycle; the increment in the write cycle uses the old config. Out-of-range cfg_idx or wr_idx (>= NUM_CNT) writes are ignored.
- snap_req: on the edge, shadow[i] <= counter value pre-increment for every i, captured simultaneously. A data write in the same cycle is not reflected in the shadow.
- Read path: combinational, zero latency from rd_idx/rd_snap to rdata. Live reads show the registered value, so a write becomes visible the cycle after we. Out-of-range rd_idx reads 0.

Test Plan:
- Reset/idle: assert reset_n=0 mid-run with counter 0 = 0x5 -> all rdata 0, ovf_flags 0 asynchronously; after release with no events, counters stay 0.
- Count and carry: sel[0]=3, event_i[3] held high, lo preloaded 0xFFFF_FFFE, hi 0 -> after 2 edges lo=0, hi=1; counter 1 (inhibited) stays 0.
- Write priority: counter 2 counting every cycle, cnt_we_lo=1, wdata=0x100 -> next cycle lo=0x100 (not 0x101), hi unchanged; next-next cycle 0x101. cnt_we_hi and cnt_we_lo together -> only hi written.
- Overflow: CNT_WIDTH=40, counter preloaded 0xFF_FFFF_FFFF, one event -> value 0, ovf_flags[i]=1, ovf_irq high exactly one cycle after wrap; a write of the lo half clears the flag.
- Snapshot coherence: counter at 0x0000_0000_FFFF_FFFF incrementing, snap_req pulse -> rd_snap=1 reads hi=0, lo=0xFFFF_FFFF for all later cycles, while the live value reads hi=1.
- Config timing/out-of-range: cfg_we in the same cycle as an event on the old sel -> counts once on the old sel, then follows the new one; wr_idx=NUM_CNT write -> no counter changes; rd_idx=NUM_CNT -> 0.
